// File: rtl/test_monitor_pkg.sv
// Shared encodings and riscv-tests constants for the end-of-test monitor.
package test_monitor_pkg;

  typedef enum logic [1:0] {
    TM_RUN     = 2'd0,
    TM_PASS    = 2'd1,
    TM_FAIL    = 2'd2,
    TM_TIMEOUT = 2'd3
  } tm_state_e;

  localparam logic [31:0] TM_PASS_VALUE      = 32'h1;
  localparam int unsigned TM_TESTNUM_SHIFT   = 1;
  localparam logic [31:0] TM_HALT_PC_DEFAULT = 32'h44;

endpackage

// File: rtl/test_monitor_sat_counter.sv
// 32-bit up-counter that sticks at all-ones instead of wrapping.
module sat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  output logic [31:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 32'd0;
    end else if (clr) begin
      count <= 32'd0;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/test_monitor.sv
// End-of-test detector: shadows the result register and reports pass/fail/timeout
// when the halt PC retires, plus cycle and retire counts for the report.
//
// state      | meaning
// TM_RUN     | test running, counters active, result register tracked
// TM_PASS    | halt retired with result == PASS_VALUE
// TM_FAIL    | halt retired with any other result
// TM_TIMEOUT | TIMEOUT cycles elapsed without halt
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter logic [31:0] HALT_PC    = TM_HALT_PC_DEFAULT,
  parameter int unsigned RESULT_REG = 3,
  parameter logic [31:0] PASS_VALUE = TM_PASS_VALUE,
  parameter int unsigned TIMEOUT    = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire_valid,
  input  logic [31:0] retire_pc,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [30:0] fail_testnum,
  output logic [31:0] cycle_count,
  output logic [31:0] retire_count
);

  localparam logic [4:0]  RES_ADDR  = 5'(RESULT_REG);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);

  tm_state_e   state, state_n;
  logic [31:0] result;
  logic [31:0] eff;
  logic        running;
  logic        wb_hit;
  logic        halt;
  logic        tmo_hit;

  assign running = (state == TM_RUN);
  // x0 is never shadowed, even if RESULT_REG is misconfigured to 0.
  assign wb_hit  = wb_en && (wb_addr == RES_ADDR) && (wb_addr != 5'd0);
  assign eff     = wb_hit ? wb_data : result;
  assign halt    = running && retire_valid && (retire_pc == HALT_PC);
  assign tmo_hit = running && (cycle_count == TMO_LAST);

  always_comb begin
    state_n = state;
    case (state)
      TM_RUN: begin
        if (halt) begin
          state_n = (eff == PASS_VALUE) ? TM_PASS : TM_FAIL;
        end else if (tmo_hit) begin
          state_n = TM_TIMEOUT;
        end
      end
      default: state_n = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= TM_RUN;
      result       <= 32'd0;
      fail_testnum <= 31'd0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state   <= state_n;
      done    <= (state_n != TM_RUN);
      pass    <= (state_n == TM_PASS);
      fail    <= (state_n == TM_FAIL);
      timeout <= (state_n == TM_TIMEOUT);
      if (running && wb_hit) begin
        result <= wb_data;
      end
      if (halt && (state_n == TM_FAIL)) begin
        fail_testnum <= 31'(eff >> TM_TESTNUM_SHIFT);
      end
    end
  end

  sat_counter u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (running),
    .clr   (1'b0),
    .count (cycle_count)
  );

  sat_counter u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (running && retire_valid),
    .clr   (1'b0),
    .count (retire_count)
  );

endmodule

// File: tb/tb_test_monitor.sv
// Scoreboard bench for test_monitor: verdict expectations are queued as stimulus
// is driven and compared once the monitor reports done.
module tb_test_monitor;

  localparam int TMO = 50;

  typedef struct {
    logic        p;
    logic        f;
    logic        t;
    logic [30:0] tn;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        d_done, d_pass, d_fail, d_timeout;
  logic [30:0] d_testnum;
  logic [31:0] d_cycle, d_retire;
  logic        z_done, z_pass, z_fail, z_timeout;
  logic [30:0] z_testnum;
  logic [31:0] z_cycle, z_retire;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  test_monitor #(.HALT_PC(32'h44), .RESULT_REG(3), .PASS_VALUE(32'h1), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .done(d_done), .pass(d_pass), .fail(d_fail), .timeout(d_timeout),
    .fail_testnum(d_testnum), .cycle_count(d_cycle), .retire_count(d_retire)
  );

  test_monitor #(.HALT_PC(32'h44), .RESULT_REG(0), .PASS_VALUE(32'h1), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .done(z_done), .pass(z_pass), .fail(z_fail), .timeout(z_timeout),
    .fail_testnum(z_testnum), .cycle_count(z_cycle), .retire_count(z_retire)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    retire_valid = 1'b0;
    retire_pc    = 32'h0;
    wb_en        = 1'b0;
    wb_addr      = 5'd3;
    wb_data      = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #7;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_verdict(input string pfx, input exp_t e);
    chk({pfx, "_done"},    d_done,    1'b1);
    chk({pfx, "_pass"},    d_pass,    e.p);
    chk({pfx, "_fail"},    d_fail,    e.f);
    chk({pfx, "_timeout"}, d_timeout, e.t);
    chk({pfx, "_testnum"}, d_testnum, e.tn);
    chk({pfx, "_cycles"},  d_cycle,   e.cyc);
    chk({pfx, "_retired"}, d_retire,  e.ret);
  endtask

  // One test run: a result write at wr_cyc, background retires, halt at halt_cyc
  // (halt_cyc >= TMO means no halt), optional same-cycle bypass write.
  task automatic run_case(input string name, input int wr_cyc, input logic [4:0] addr,
                          input logic [31:0] wr_val, input int halt_cyc,
                          input logic byp, input logic [31:0] byp_val,
                          output exp_t e);
    int          ret_n = 0;
    int          last;
    logic [31:0] eff = 32'h0;
    exp_t        got;
    last = (halt_cyc < TMO) ? halt_cyc : TMO - 1;
    for (int c = 0; c <= last; c++) begin
      idle_inputs();
      wb_addr = addr;
      if (c == 0) chk({name, "_cyc_start"}, d_cycle, 32'd0);
      if (c == wr_cyc) begin
        wb_en   = 1'b1;
        wb_data = wr_val;
        if (addr == 5'd3) eff = wr_val;
      end
      if (c % 3 == 1) begin
        retire_valid = 1'b1;
        retire_pc    = 32'h200 + 32'(4 * c);
      end
      if (c == halt_cyc) begin
        retire_valid = 1'b1;
        retire_pc    = 32'h44;
        if (byp) begin
          wb_en   = 1'b1;
          wb_data = byp_val;
          if (addr == 5'd3) eff = byp_val;
        end
      end
      if (retire_valid) ret_n++;
      if (c == last) begin
        if (halt_cyc < TMO) begin
          e.p   = (eff == 32'h1);
          e.f   = (eff != 32'h1);
          e.t   = 1'b0;
          e.tn  = e.f ? eff[31:1] : 31'd0;
          e.cyc = 32'(halt_cyc + 1);
        end else begin
          e.p   = 1'b0;
          e.f   = 1'b0;
          e.t   = 1'b1;
          e.tn  = 31'd0;
          e.cyc = 32'(TMO);
        end
        e.ret = 32'(ret_n);
        sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      if (c == last - 1) chk({name, "_not_done_yet"}, d_done, 1'b0);
    end
    idle_inputs();
    for (int k = 0; k < 4 && !d_done; k++) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_done_seen"}, d_done, 1'b1);
    if (sbq.size() != 0) begin
      got = sbq.pop_front();
      check_verdict(name, got);
    end else begin
      chk({name, "_sbq_empty"}, 1'b1, 1'b0);
    end
  endtask

  // Further halts, result writes and clocks after a verdict must change nothing.
  task automatic post_verdict(input string name, input exp_t e);
    for (int c = 0; c < 5; c++) begin
      retire_valid = 1'b1;
      retire_pc    = 32'h44;
      wb_en        = 1'b1;
      wb_addr      = 5'd3;
      wb_data      = (c % 2 == 0) ? 32'h1 : 32'h0B;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    check_verdict({name, "_frozen"}, e);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] rv;
    rst = 1'b1;
    idle_inputs();
    #2;
    chk("rst_done",    d_done,    1'b0);
    chk("rst_pass",    d_pass,    1'b0);
    chk("rst_testnum", d_testnum, 31'd0);
    chk("rst_cycles",  d_cycle,   32'd0);
    chk("rst_retired", d_retire,  32'd0);

    do_reset();
    run_case("pass", 10, 5'd3, 32'h1, 20, 1'b0, 32'h0, e);
    post_verdict("pass", e);

    do_reset();
    run_case("fail", 5, 5'd3, 32'h0B, 15, 1'b0, 32'h0, e);
    chk("fail_tn5", d_testnum, 31'd5);

    do_reset();
    run_case("bypass", 5, 5'd3, 32'h0B, 12, 1'b1, 32'h1, e);

    do_reset();
    rv = $urandom() | 32'h8000_0000;
    run_case("rand_fail", 3, 5'd3, rv, 30, 1'b0, 32'h0, e);

    do_reset();
    run_case("timeout", 5, 5'd3, 32'h0B, 1000, 1'b0, 32'h0, e);
    post_verdict("timeout", e);

    do_reset();
    run_case("edge_pass", 5, 5'd3, 32'h1, TMO - 1, 1'b0, 32'h0, e);

    do_reset();
    run_case("edge_fail", 5, 5'd3, 32'h7, TMO - 1, 1'b0, 32'h0, e);
    chk("edge_fail_tn3", d_testnum, 31'd3);

    do_reset();
    run_case("pass2", 2, 5'd3, 32'h1, 8, 1'b0, 32'h0, e);
    #2;
    rst = 1'b1;
    #1;
    chk("async_done",    d_done,    1'b0);
    chk("async_pass",    d_pass,    1'b0);
    chk("async_testnum", d_testnum, 31'd0);
    chk("async_cycles",  d_cycle,   32'd0);
    chk("async_retired", d_retire,  32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_case("x0", 3, 5'd0, 32'h1, 8, 1'b1, 32'h1, e);
    chk("x0_z_fail",    z_fail,    1'b1);
    chk("x0_z_pass",    z_pass,    1'b0);
    chk("x0_z_testnum", z_testnum, 31'd0);
    chk("x0_z_cycles",  z_cycle,   32'd9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
